// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch front-end feeding decode from direct_cache.
//           Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] ResetPc   = 32'h0000_0000,
  parameter int          FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] cache_addr_o,
  output logic        cache_read_en_o,
  input  logic        cache_read_valid_i,
  input  logic [31:0] cache_read_word_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_wait_cnt_o,
`endif
  input  logic        instr_ready_i
);

  localparam int          c_ptr_w    = $clog2(FifoDepth);
  localparam int          c_cnt_w    = c_ptr_w + 1;
  localparam logic [31:0] c_reset_pc = ResetPc & ~32'h3;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FifoDepth);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_fetch_pc;
  logic [31:0]          r_stored_target;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [31:0]          r_mem_instr [FifoDepth];
  logic [31:0]          r_mem_pc    [FifoDepth];

  logic                 w_complete;
  logic                 w_push;
  logic                 w_pop;
  logic [c_cnt_w-1:0]   w_count_next;
  logic                 w_space;
  logic [31:0]          w_redir_pc;

  assign cache_addr_o    = r_fetch_pc;
  assign cache_read_en_o = (r_state == REQ) || (r_state == DISCARD);
  assign instr_valid_o   = (r_count != '0);
  assign instr_o         = r_mem_instr[r_rd_ptr];
  assign instr_pc_o      = r_mem_pc[r_rd_ptr];

  assign w_redir_pc   = redirect_pc_i & ~32'h3;
  assign w_complete   = cache_read_en_o && cache_read_valid_i;
  assign w_push       = (r_state == REQ) && w_complete && !redirect_i;
  assign w_pop        = instr_valid_o && instr_ready_i && !redirect_i;
  // A redirect empties the FIFO, so the next fetch always has room.
  assign w_count_next = redirect_i ? '0
                      : r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  assign w_space      = (w_count_next < c_depth);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_fetch_pc      <= c_reset_pc;
      r_stored_target <= c_reset_pc;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_i) r_fetch_pc <= w_redir_pc;
          if (w_space)    r_state    <= REQ;
        end
        REQ: begin
          if (w_complete && !redirect_i) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= w_space ? REQ : IDLE;
          end else if (redirect_i && !w_complete) begin
            // Address must stay stable until the cache answers.
            r_stored_target <= w_redir_pc;
            r_state         <= DISCARD;
          end else if (redirect_i && w_complete) begin
            r_fetch_pc <= w_redir_pc;
          end
        end
        DISCARD: begin
          if (w_complete) begin
            r_fetch_pc <= redirect_i ? w_redir_pc : r_stored_target;
            r_state    <= REQ;
          end else if (redirect_i) begin
            r_stored_target <= w_redir_pc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else begin
      r_count <= w_count_next;
      if (redirect_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_instr[r_wr_ptr] <= cache_read_word_i;
          r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
          r_wr_ptr              <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_wait_cnt;

  assign perf_fetch_cnt_o = r_perf_fetch_cnt;
  assign perf_wait_cnt_o  = r_perf_wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetch_cnt <= '0;
      r_perf_wait_cnt  <= '0;
    end else begin
      if (w_push) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (cache_read_en_o && !cache_read_valid_i)
        r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
